pcm_tone_gen: RTL
=================

// Module: pcm_tone_gen
// PURPOSE
//  Parametrised multi-channel PCM test-tone source that replaces the fixed 64-entry sine case table.
//  Each channel has a DDS phase accumulator, selectable waveform (sine/square/saw/mute) and amplitude scale.
//  Channels are computed one per cycle on a single shared quarter-wave ROM; one frame is produced per tick.
//  Frames go out over a valid/ready handshake into the sample FIFO that feeds the audio controller.
// PARAMETERS
//  NUM_CH      2   channel count (1..8); lane n of every packed bus is channel n
//  SAMPLE_W    20  signed PCM sample width
//  PHASE_W     24  phase accumulator width; must be >= SAMPLE_W and >= LUT_ADDR_W+2
//  LUT_ADDR_W  4   quarter-wave ROM address width (2^LUT_ADDR_W entries, 4x that per cycle)
//  AMP_W       8   unsigned amplitude width
// PORTS
//  clk         in   1                 system clock (clk100 domain)
//  rst         in   1                 asynchronous, active-high reset
//  enable      in   1                 1: ticks start frames; 0: ticks ignored, phases held
//  sample_tick in   1                 single-cycle frame request, already synchronised to clk
//  phase_clr   in   1                 pulse: zero all phase accumulators
//  freq_word   in   NUM_CH*PHASE_W    per-channel phase increment
//  amp         in   NUM_CH*AMP_W      per-channel amplitude
//  mode        in   NUM_CH*2          per-channel waveform: 0 sine, 1 square, 2 saw, 3 mute
//  out_data    out  NUM_CH*SAMPLE_W   packed signed samples of one frame
//  out_valid   out  1                 frame valid; held until accepted
//  out_ready   in   1                 sink accepts (FIFO not full)
//  busy        out  1                 frame in progress or pending
//  overrun     out  1                 sticky: a tick was dropped; cleared only by rst
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, busy=0, overrun=0, all phases=0, FSM=IDLE.
//  - FSM states: IDLE, CALC, HOLD.
//  - IDLE: on sample_tick&&enable, latch freq_word/amp/mode, busy=1, go to CALC.
//    Ticks with enable=0 are ignored; phases hold and overrun is not set.
//  - CALC: channel index ch=0..NUM_CH-1, one per cycle, into a 3-stage pipe (lookup, scale, store).
//    Output uses the pre-increment phase; phase[ch] += freq_word[ch] mod 2^PHASE_W.
//  - When the last lane is stored: out_valid=1, go to HOLD. out_valid rises exactly NUM_CH+3 cycles after the tick.
//  - HOLD: out_data is stable while out_valid=1. On out_valid&&out_ready: out_valid=0, busy=0, go to IDLE
//    the next cycle. A tick in that same cycle is dropped and sets overrun.
//  - Any tick while busy=1 is dropped: overrun=1, and no phase advances for that tick.
//  - phase_clr: if busy=0, zero phases next cycle. If busy=1, defer; phases zero at the HOLD->IDLE transition.
//    If phase_clr coincides with an accepted tick in IDLE, the clear wins and this frame uses phase 0.
//  - Waveforms, with FS = 2^(SAMPLE_W-1)-1, p = phase, q = p[PHASE_W-1:PHASE_W-2], i = next LUT_ADDR_W bits:
//    - sine: ROM Q[k] = round(FS*sin(pi/2*(k+0.5)/2^LUT_ADDR_W)).
//      Address k = i for q=0,2 and ~i for q=1,3; the value is negated for q=2,3.
//    - square: +FS if p[MSB]=0, else -FS.
//    - saw: p[PHASE_W-1 -: SAMPLE_W] read as signed.
//    - mute: 0, phase still advances.
//  - Scaling: out = (wave * amp) >>> AMP_W, with wave signed and amp zero-extended.
//    Full-width product, arithmetic shift (floor), truncated to SAMPLE_W; cannot overflow.
//  - enable dropping mid-frame does not abort the frame; it completes and is delivered.
//  - Async rst mid-frame aborts immediately; the partial frame is never presented.
// STRUCTURE
//  - audio_pkg: mode encodings (MODE_SINE/SQUARE/SAW/MUTE), FSM state encoding, function full_scale(SAMPLE_W).
//  - Sub-module sine_quarter_rom: parametrised by SAMPLE_W and LUT_ADDR_W, table generated at elaboration,
//    registered output (pipe stage 1), synchronous read.
//  - Phase accumulators: NUM_CH x PHASE_W register array, indexed by ch; a single shared multiplier.
// TESTING (NUM_CH=2, SAMPLE_W=20, PHASE_W=24, LUT_ADDR_W=4, AMP_W=8)
//  1. Reset, then tick with ch0 sine, freq=0x040000, amp=0xFF -> out_valid 5 cycles later;
//     lane0 = (Q[0]*255)>>>8, Q[0]=0x0647E; 64 ticks trace the full period, and tick 65 equals tick 1.
//  2. ch1 square, freq=0x800000, amp=0x80, consecutive frames -> lane1 alternates 0x3FFFF, 0xC0000.
//  3. out_ready=0 for 20 cycles with 2 extra ticks -> out_data stable, overrun=1;
//     after accept, the next frame shows the phase advanced by only one step.
//  4. Tick with enable=0 -> no out_valid, overrun stays 0, phases unchanged on the next enabled frame.
//  5. phase_clr while busy, then the next tick -> sample equals the phase-0 value; mode=3 -> lane=0.
//  6. Assert rst in CALC -> all outputs 0 within the same cycle; first frame after release matches test 1.

Source files
------------

// File: rtl/pcm_tone_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcm_tone_gen_pkg
// Brief    : Shared encodings for the PCM test-tone generator: waveform modes,
//            frame FSM states and the full-scale helper.
// Revision : 1.0 - initial release
// ============================================================================
package pcm_tone_gen_pkg;

    // Waveform selection, one 2-bit field per channel
    localparam logic [1:0] c_mode_sine   = 2'd0;
    localparam logic [1:0] c_mode_square = 2'd1;
    localparam logic [1:0] c_mode_saw    = 2'd2;
    localparam logic [1:0] c_mode_mute   = 2'd3;

    // Frame FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    // Largest positive value of a signed sample of the given width
    function automatic int full_scale(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_tone_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pcm_tone_gen_if
// Brief    : Frame handshake between the tone generator and the sample FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface pcm_tone_gen_if #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 20
);
    logic [NUM_CH*SAMPLE_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/pcm_tone_gen_sine_rom.sv
`default_nettype none
// ============================================================================
// Module   : sine_quarter_rom
// Brief    : Quarter-wave sine table sampled at bin centres, built at
//            elaboration, read synchronously (registered output).
// Revision : 1.0 - initial release
// ============================================================================
module sine_quarter_rom import pcm_tone_gen_pkg::*; #(
    parameter int SAMPLE_W   = 20,
    parameter int LUT_ADDR_W = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [LUT_ADDR_W-1:0] i_addr,
    output logic      [SAMPLE_W-1:0]   o_data
);
    localparam int  c_depth   = 1 << LUT_ADDR_W;
    localparam real c_pi      = 3.14159265358979323846;
    localparam real c_fs_real = real'(full_scale(SAMPLE_W));

    logic [SAMPLE_W-1:0] w_table [c_depth];

    // Half-bin offset keeps the table symmetric about the quadrant edges
    for (genvar k = 0; k < c_depth; k++) begin : g_entry
        localparam real c_angle = c_pi / 2.0 * (real'(k) + 0.5) / real'(c_depth);
        localparam int  c_val   = $rtoi(c_fs_real * $sin(c_angle) + 0.5);
        assign w_table[k] = SAMPLE_W'(c_val);
    end

    // Registered lookup: first stage of the sample pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
        end else begin
            o_data <= w_table[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcm_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : pcm_tone_gen
// Brief    : Multi-channel DDS test-tone source. One channel is computed per
//            cycle through lookup/scale/store stages; a full frame is offered
//            on a valid/ready handshake for every accepted sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_tone_gen import pcm_tone_gen_pkg::*; #(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 20,
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 4,
    parameter int AMP_W      = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       enable,
    input  wire logic                       sample_tick,
    input  wire logic                       phase_clr,
    input  wire logic [NUM_CH*PHASE_W-1:0]  freq_word,
    input  wire logic [NUM_CH*AMP_W-1:0]    amp,
    input  wire logic [NUM_CH*2-1:0]        mode,
    pcm_tone_gen_if.master                  out_if,
    output logic                            busy,
    output logic                            overrun
);
    localparam int c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_prod_w = SAMPLE_W + AMP_W + 1;
    localparam logic [c_ch_w-1:0]          c_last_ch = c_ch_w'(NUM_CH - 1);
    localparam logic signed [SAMPLE_W-1:0] c_fs      = SAMPLE_W'(full_scale(SAMPLE_W));

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic                       r_issuing;
    logic [c_ch_w-1:0]          r_ch;
    logic [NUM_CH*PHASE_W-1:0]  r_freq;
    logic [NUM_CH*AMP_W-1:0]    r_amp;
    logic [NUM_CH*2-1:0]        r_mode;
    logic [PHASE_W-1:0]         r_phase [NUM_CH];
    logic                       r_clr_pending;
    logic                       r_overrun;

    logic                       r_s1_vld, r_s1_last, r_s1_upper;
    logic [c_ch_w-1:0]          r_s1_ch;
    logic [SAMPLE_W-1:0]        r_s1_saw;
    logic [1:0]                 r_s1_mode;
    logic [AMP_W-1:0]           r_s1_amp;
    logic [SAMPLE_W-1:0]        w_rom_q;

    logic                       r_s2_vld, r_s2_last;
    logic [c_ch_w-1:0]          r_s2_ch;
    logic [SAMPLE_W-1:0]        r_s2_sample;

    logic [NUM_CH*SAMPLE_W-1:0] r_out_data;
    logic                       r_stored_last;

    logic                       w_busy, w_tick_ok, w_accept, w_clr_now;
    logic [PHASE_W-1:0]         w_phase, w_freq;
    logic [1:0]                 w_quad;
    logic [LUT_ADDR_W-1:0]      w_idx, w_rom_addr;
    logic signed [SAMPLE_W-1:0] w_wave;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [SAMPLE_W-1:0] w_sample;

    assign w_busy    = (r_state != c_st_idle);
    assign w_tick_ok = sample_tick && enable && !w_busy;
    assign w_accept  = (r_state == c_st_hold) && out_if.out_ready;
    // A clear seen while busy waits for the frame hand-off so the frame in flight keeps its phases
    assign w_clr_now = (phase_clr && !w_busy) || (w_accept && (phase_clr || r_clr_pending));

    assign w_phase    = r_phase[r_ch];
    assign w_freq     = r_freq[r_ch*PHASE_W +: PHASE_W];
    assign w_quad     = w_phase[PHASE_W-1 -: 2];
    assign w_idx      = w_phase[PHASE_W-3 -: LUT_ADDR_W];
    assign w_rom_addr = w_quad[0] ? ~w_idx : w_idx;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: calc until the last lane lands, hold until accepted
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_tick_ok)         w_state_next = c_st_calc;
            c_st_calc: if (r_stored_last)     w_state_next = c_st_hold;
            c_st_hold: if (out_if.out_ready)  w_state_next = c_st_idle;
            default:                          w_state_next = c_st_idle;
        endcase
    end

    // Latch the frame configuration and step the channel issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issuing <= 1'b0;
            r_ch      <= '0;
            r_freq    <= '0;
            r_amp     <= '0;
            r_mode    <= '0;
        end else if (w_tick_ok) begin
            r_issuing <= 1'b1;
            r_ch      <= '0;
            r_freq    <= freq_word;
            r_amp     <= amp;
            r_mode    <= mode;
        end else if (r_issuing) begin
            if (r_ch == c_last_ch) begin
                r_issuing <= 1'b0;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // Sticky overrun and deferred phase clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun     <= 1'b0;
            r_clr_pending <= 1'b0;
        end else begin
            if (sample_tick && w_busy) r_overrun <= 1'b1;
            if (w_accept) begin
                r_clr_pending <= 1'b0;
            end else if (phase_clr && w_busy) begin
                r_clr_pending <= 1'b1;
            end
        end
    end

    // Phase accumulators: clear has priority, otherwise advance the issued channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
        end else if (w_clr_now) begin
            for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
        end else if (r_issuing) begin
            r_phase[r_ch] <= w_phase + w_freq;
        end
    end

    sine_quarter_rom #(
        .SAMPLE_W   (SAMPLE_W),
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_rom_addr),
        .o_data (w_rom_q)
    );

    // Lookup stage: carry the pre-increment phase fields alongside the ROM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_upper <= 1'b0;
            r_s1_saw   <= '0;
            r_s1_mode  <= '0;
            r_s1_amp   <= '0;
        end else begin
            r_s1_vld   <= r_issuing;
            r_s1_last  <= (r_ch == c_last_ch);
            r_s1_ch    <= r_ch;
            r_s1_upper <= w_quad[1];
            r_s1_saw   <= w_phase[PHASE_W-1 -: SAMPLE_W];
            r_s1_mode  <= r_mode[r_ch*2 +: 2];
            r_s1_amp   <= r_amp[r_ch*AMP_W +: AMP_W];
        end
    end

    // Waveform select; phase MSB doubles as the sine sign and the square level
    always_comb begin
        w_wave = '0;
        case (r_s1_mode)
            c_mode_sine:   w_wave = r_s1_upper ? -$signed(w_rom_q) : $signed(w_rom_q);
            c_mode_square: w_wave = r_s1_upper ? -c_fs : c_fs;
            c_mode_saw:    w_wave = $signed(r_s1_saw);
            default:       w_wave = '0;
        endcase
    end

    // One shared multiplier; floor shift of a full-width product never overflows
    assign w_prod   = w_wave * $signed({1'b0, r_s1_amp});
    assign w_sample = SAMPLE_W'(w_prod >>> AMP_W);

    // Scale stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_ch     <= '0;
            r_s2_sample <= '0;
        end else begin
            r_s2_vld    <= r_s1_vld;
            r_s2_last   <= r_s1_vld && r_s1_last;
            r_s2_ch     <= r_s1_ch;
            r_s2_sample <= w_sample;
        end
    end

    // Store stage: write the lane and flag completion of the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data    <= '0;
            r_stored_last <= 1'b0;
        end else begin
            if (r_s2_vld) r_out_data[r_s2_ch*SAMPLE_W +: SAMPLE_W] <= r_s2_sample;
            r_stored_last <= r_s2_vld && r_s2_last;
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = (r_state == c_st_hold);
    assign busy             = w_busy;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire
